npc_lsu: RTL and testbench
==========================

// Module: npc_lsu
// PURPOSE
//  Load/store unit: initiator side of the NPC data-memory DPI port (valid/wen/raddr/waddr/wdata/wmask -> rdata).
//  Accepts one load/store from execute via valid/ready, issues one single-cycle memory access, returns aligned data.
//  Generates byte masks and data shifts, sign/zero-extends loads, and flags misaligned accesses without touching memory.
//  Sits between EXU and the memory model; one outstanding request at a time.
// PARAMETERS
//  XLEN     32  data/address width
//  LATENCY  0   extra wait cycles (0..15) inserted before the access cycle, to emulate a slow memory
// PORTS
//  clk            in   1     clock
//  rst            in   1     synchronous reset, active-high
//  req_valid      in   1     EXU presents a request
//  req_ready      out  1     LSU can accept (high only in IDLE)
//  req_wen        in   1     1 = store, 0 = load
//  req_addr       in   XLEN  byte address
//  req_wdata      in   XLEN  store data, LSB-justified
//  req_size       in   2     0 = byte, 1 = half, 2 = word; 3 is illegal and treated as misaligned
//  req_unsigned   in   1     loads: 1 = zero-extend, 0 = sign-extend
//  resp_valid     out  1     result available
//  resp_ready     in   1     EXU/WBU consumes result
//  resp_rdata     out  XLEN  extended load data; 0 for stores and for faults
//  resp_misalign  out  1     access was misaligned or had an illegal size; no memory access was made
//  mem_valid      out  1     memory access strobe
//  mem_wen        out  1     write enable
//  mem_raddr      out  XLEN  word-aligned read address
//  mem_waddr      out  XLEN  word-aligned write address
//  mem_wdata      out  XLEN  lane-shifted write data
//  mem_wmask      out  8     byte-lane mask; bits [7:4] are always 0
//  mem_rdata      in   XLEN  combinational read data, valid in the same cycle as mem_valid
// BEHAVIOUR
//  Reset:
//   - state = IDLE; req_ready = 1.
//   - resp_valid, resp_rdata, resp_misalign, and all mem_* outputs are 0.
//  FSM: IDLE -> (WAIT) -> ACCESS -> RESP -> IDLE.
//   IDLE:
//    - Accept on req_valid & req_ready; latch all req_* fields.
//    - Misaligned (half with addr[0]=1, word with addr[1:0]!=0, or size 3): go directly to RESP with resp_misalign=1.
//    - Otherwise go to WAIT if LATENCY>0, else ACCESS.
//   WAIT:
//    - Counter counts LATENCY cycles, then moves to ACCESS. mem_valid stays 0.
//   ACCESS:
//    - Exactly one cycle: mem_valid=1, mem_wen=latched wen.
//    - The memory side fires writes on every evaluation while valid, so mem_valid and mem_wen must never be high for more than one cycle per request.
//    - The load result is computed from mem_rdata and registered this cycle. Next state is RESP.
//   RESP:
//    - resp_valid=1 and outputs are held stable until resp_ready; then go to IDLE.
//    - req_ready becomes 1 the cycle after the handshake. There is no request/response overlap.
//  Address and data:
//   - mem_raddr = mem_waddr = {addr[XLEN-1:2], 2'b00}; off = addr[1:0].
//   - wmask: byte 4'b0001<<off, half 4'b0011<<off, word 4'b1111. mem_wdata = wdata << (8*off).
//   - Loads: shifted = mem_rdata >> (8*off); take byte[7:0] or half[15:0] and extend per req_unsigned; word passes through unchanged.
//  Latency: an aligned access with LATENCY=0 gives accept at cycle t, ACCESS at t+1, resp_valid at t+2. A misaligned request gives resp_valid at t+1.
//  Boundaries:
//   - When mem_valid=0, all mem_* outputs are 0, so the memory model returns rdata=0.
//   - rst in any state returns to IDLE on the next edge. Any in-flight response is discarded and no further mem_valid is issued.
//   - req_valid during WAIT, ACCESS or RESP is ignored (req_ready=0).
// STRUCTURE
//  Shared package npc_pkg: LSU size encodings (SZ_B/SZ_H/SZ_W) and the FSM state enum (IDLE/WAIT/ACCESS/RESP).
//  Sub-module npc_lsu_align (combinational): inputs size, off, wdata, rdata, unsigned; outputs wmask, shifted wdata, extended rdata.
//  Top level holds the FSM, the request latch, the WAIT counter and the response registers.
// TESTING
//  1. sw 0xDEADBEEF @0x80000004 -> one mem_valid cycle: waddr 0x80000004, wmask 0x0F, wdata 0xDEADBEEF; resp_rdata 0.
//  2. sb 0x000000A5 @0x80000003 -> wmask 0x08, wdata 0xA5000000; following lbu @0x80000003 -> 0x000000A5; lb -> 0xFFFFFFA5.
//  3. lh @0x80000002 with mem_rdata 0x8001_1234 -> 0xFFFF8001; lhu -> 0x00008001.
//  4. lw @0x80000002 and lh @0x80000001 -> resp_misalign=1 at t+1, mem_valid never asserted.
//  5. LATENCY=3, resp_ready held low 5 cycles -> exactly one mem_valid pulse at t+4, resp stable until ready, req_ready=0 throughout.
//  6. rst asserted during WAIT and during RESP -> next cycle IDLE, resp_valid=0, no mem_valid pulse afterwards.

Source files
------------

// File: rtl/npc_pkg.sv
// Shared encodings for the NPC load/store unit: access sizes, FSM states and
// the alignment rule used to decide whether a request may touch memory.
package npc_pkg;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Size 3 has no legal encoding, so it is reported the same way as a misalignment.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        logic bad;
        case (size)
            SZ_B:    bad = 1'b0;
            SZ_H:    bad = off[0];
            SZ_W:    bad = (off != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/npc_lsu_align.sv
// Byte-lane steering for the LSU: store mask/data placement within the word
// and load extraction with sign or zero extension.
module npc_lsu_align
    import npc_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]      i_size,
    input  logic [1:0]      i_off,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [XLEN-1:0] i_rdata,
    input  logic            i_unsigned,
    output logic [3:0]      o_wmask,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_rdata
);

    logic [4:0]      w_shamt;
    logic [XLEN-1:0] w_shifted;
    logic            w_sign_b;
    logic            w_sign_h;

    assign w_shamt   = {i_off, 3'b000};
    assign o_wdata   = i_wdata << w_shamt;
    assign w_shifted = i_rdata >> w_shamt;
    assign w_sign_b  = ~i_unsigned & w_shifted[7];
    assign w_sign_h  = ~i_unsigned & w_shifted[15];

    always_comb begin
        o_wmask = 4'b0000;
        case (i_size)
            SZ_B:    o_wmask = 4'b0001 << i_off;
            SZ_H:    o_wmask = 4'b0011 << i_off;
            SZ_W:    o_wmask = 4'b1111;
            default: o_wmask = 4'b0000;
        endcase
    end

    always_comb begin
        o_rdata = w_shifted;
        case (i_size)
            SZ_B:    o_rdata = {{(XLEN-8){w_sign_b}}, w_shifted[7:0]};
            SZ_H:    o_rdata = {{(XLEN-16){w_sign_h}}, w_shifted[15:0]};
            default: o_rdata = w_shifted;
        endcase
    end

endmodule

// File: rtl/npc_lsu.sv
// Load/store unit: takes one request at a time from execute, issues a single
// one-cycle memory access (after optional wait cycles) and holds the response.
module npc_lsu
    import npc_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int LATENCY = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_wen,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    input  logic [1:0]      i_req_size,
    input  logic            i_req_unsigned,
    output logic            o_resp_valid,
    input  logic            i_resp_ready,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic            o_resp_misalign,
    output logic            o_mem_valid,
    output logic            o_mem_wen,
    output logic [XLEN-1:0] o_mem_raddr,
    output logic [XLEN-1:0] o_mem_waddr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [7:0]      o_mem_wmask,
    input  logic [XLEN-1:0] i_mem_rdata
);

    localparam logic       HAS_WAIT = (LATENCY > 0);
    localparam logic [3:0] LAT_LAST = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    logic [1:0]      r_state;
    logic [3:0]      r_cnt;
    logic            r_wen;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [1:0]      r_size;
    logic            r_unsigned;
    logic [XLEN-1:0] r_rdata;
    logic            r_misalign;

    logic            w_access;
    logic [3:0]      w_wmask;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load;
    logic [XLEN-1:0] w_word_addr;

    npc_lsu_align #(.XLEN(XLEN)) u_align (
        .i_size     (r_size),
        .i_off      (r_addr[1:0]),
        .i_wdata    (r_wdata),
        .i_rdata    (i_mem_rdata),
        .i_unsigned (r_unsigned),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata),
        .o_rdata    (w_load)
    );

    assign w_access    = (r_state == ST_ACCESS);
    assign w_word_addr = {r_addr[XLEN-1:2], 2'b00};

    // Memory port is forced to zero outside ACCESS so a write can never repeat.
    assign o_mem_valid = w_access;
    assign o_mem_wen   = w_access & r_wen;
    assign o_mem_raddr = w_access ? w_word_addr : '0;
    assign o_mem_waddr = w_access ? w_word_addr : '0;
    assign o_mem_wdata = w_access ? w_wdata : '0;
    assign o_mem_wmask = w_access ? {4'b0000, w_wmask} : 8'h00;

    assign o_req_ready     = (r_state == ST_IDLE);
    assign o_resp_valid    = (r_state == ST_RESP);
    assign o_resp_rdata    = r_rdata;
    assign o_resp_misalign = r_misalign;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cnt      <= 4'd0;
            r_wen      <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_size     <= SZ_B;
            r_unsigned <= 1'b0;
            r_rdata    <= '0;
            r_misalign <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_wen      <= i_req_wen;
                        r_addr     <= i_req_addr;
                        r_wdata    <= i_req_wdata;
                        r_size     <= i_req_size;
                        r_unsigned <= i_req_unsigned;
                        r_rdata    <= '0;
                        r_cnt      <= 4'd0;
                        if (is_misaligned(i_req_size, i_req_addr[1:0])) begin
                            r_misalign <= 1'b1;
                            r_state    <= ST_RESP;
                        end else begin
                            r_misalign <= 1'b0;
                            r_state    <= HAS_WAIT ? ST_WAIT : ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == LAT_LAST) begin
                        r_state <= ST_ACCESS;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                ST_ACCESS: begin
                    r_rdata <= r_wen ? '0 : w_load;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    // Clearing on handshake keeps resp outputs at zero while idle.
                    if (i_resp_ready) begin
                        r_rdata    <= '0;
                        r_misalign <= 1'b0;
                        r_state    <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_npc_lsu.sv
// Directed bench for npc_lsu: a zero-latency instance backed by a small byte-lane
// memory and a three-cycle-latency instance backed by a fixed read pattern.
module tb_npc_lsu;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // Zero-latency instance
    logic        rst0, req_valid0, req_wen0, req_unsigned0, resp_ready0;
    logic [31:0] req_addr0, req_wdata0;
    logic [1:0]  req_size0;
    logic        req_ready0, resp_valid0, resp_mis0, mem_valid0, mem_wen0;
    logic [31:0] resp_rdata0, mem_raddr0, mem_waddr0, mem_wdata0, mem_rdata0;
    logic [7:0]  mem_wmask0;

    // Latency-3 instance
    logic        rst3, req_valid3, req_wen3, req_unsigned3, resp_ready3;
    logic [31:0] req_addr3, req_wdata3;
    logic [1:0]  req_size3;
    logic        req_ready3, resp_valid3, resp_mis3, mem_valid3, mem_wen3;
    logic [31:0] resp_rdata3, mem_raddr3, mem_waddr3, mem_wdata3, mem_rdata3;
    logic [7:0]  mem_wmask3;

    npc_lsu #(.XLEN(32), .LATENCY(0)) dut0 (
        .i_clk(clk), .i_rst(rst0),
        .i_req_valid(req_valid0), .o_req_ready(req_ready0),
        .i_req_wen(req_wen0), .i_req_addr(req_addr0), .i_req_wdata(req_wdata0),
        .i_req_size(req_size0), .i_req_unsigned(req_unsigned0),
        .o_resp_valid(resp_valid0), .i_resp_ready(resp_ready0),
        .o_resp_rdata(resp_rdata0), .o_resp_misalign(resp_mis0),
        .o_mem_valid(mem_valid0), .o_mem_wen(mem_wen0),
        .o_mem_raddr(mem_raddr0), .o_mem_waddr(mem_waddr0),
        .o_mem_wdata(mem_wdata0), .o_mem_wmask(mem_wmask0),
        .i_mem_rdata(mem_rdata0)
    );

    npc_lsu #(.XLEN(32), .LATENCY(3)) dut3 (
        .i_clk(clk), .i_rst(rst3),
        .i_req_valid(req_valid3), .o_req_ready(req_ready3),
        .i_req_wen(req_wen3), .i_req_addr(req_addr3), .i_req_wdata(req_wdata3),
        .i_req_size(req_size3), .i_req_unsigned(req_unsigned3),
        .o_resp_valid(resp_valid3), .i_resp_ready(resp_ready3),
        .o_resp_rdata(resp_rdata3), .o_resp_misalign(resp_mis3),
        .o_mem_valid(mem_valid3), .o_mem_wen(mem_wen3),
        .o_mem_raddr(mem_raddr3), .o_mem_waddr(mem_waddr3),
        .o_mem_wdata(mem_wdata3), .o_mem_wmask(mem_wmask3),
        .i_mem_rdata(mem_rdata3)
    );

    // Byte-lane memory for dut0; word 0 preloaded on reset.
    logic [31:0] mem [16];
    assign mem_rdata0 = mem_valid0 ? mem[mem_raddr0[5:2]] : 32'h0;
    assign mem_rdata3 = mem_valid3 ? 32'h1357_9BDF : 32'h0;

    int pulses0 = 0;
    int pulses3 = 0;

    always @(posedge clk) begin
        if (rst0) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h8001_1234;
        end else if (mem_valid0 && mem_wen0) begin
            for (int b = 0; b < 4; b++)
                if (mem_wmask0[b]) mem[mem_waddr0[5:2]][8*b +: 8] <= mem_wdata0[8*b +: 8];
        end
        if (mem_valid0) pulses0 <= pulses0 + 1;
        if (mem_valid3) pulses3 <= pulses3 + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic xact0(input string tag, input logic wen, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                         input logic mis, input logic [7:0] ewmask, input logic [31:0] ewdata,
                         input logic [31:0] erdata);
        int p;
        p = pulses0;
        req_valid0 = 1'b1; req_wen0 = wen; req_addr0 = addr;
        req_wdata0 = wdata; req_size0 = size; req_unsigned0 = uns;
        chk({tag, ".req_ready"}, 32'(req_ready0), 32'd1);
        tick();
        req_valid0 = 1'b0;
        if (!mis) begin
            chk({tag, ".mem_valid"}, 32'(mem_valid0), 32'd1);
            chk({tag, ".mem_wen"},   32'(mem_wen0), 32'(wen));
            chk({tag, ".raddr"},     mem_raddr0, {addr[31:2], 2'b00});
            chk({tag, ".waddr"},     mem_waddr0, {addr[31:2], 2'b00});
            chk({tag, ".wmask"},     32'(mem_wmask0), 32'(ewmask));
            chk({tag, ".wdata"},     mem_wdata0, ewdata);
            chk({tag, ".early_resp"}, 32'(resp_valid0), 32'd0);
            tick();
        end
        chk({tag, ".resp_valid"}, 32'(resp_valid0), 32'd1);
        chk({tag, ".rdata"},      resp_rdata0, erdata);
        chk({tag, ".misalign"},   32'(resp_mis0), 32'(mis));
        chk({tag, ".mem_idle"},   32'(mem_valid0), 32'd0);
        chk({tag, ".busy"},       32'(req_ready0), 32'd0);
        resp_ready0 = 1'b1;
        tick();
        resp_ready0 = 1'b0;
        chk({tag, ".resp_done"}, 32'(resp_valid0), 32'd0);
        chk({tag, ".ready_back"}, 32'(req_ready0), 32'd1);
        chk({tag, ".pulses"}, 32'(pulses0 - p), mis ? 32'd0 : 32'd1);
        $display("xact %s wen=%0d addr=%h size=%0d rdata=%h mis=%0d",
                 tag, wen, addr, size, resp_rdata0, mis);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int p;
        rst0 = 1'b1; req_valid0 = 0; req_wen0 = 0; req_addr0 = 0; req_wdata0 = 0;
        req_size0 = 0; req_unsigned0 = 0; resp_ready0 = 0;
        rst3 = 1'b1; req_valid3 = 0; req_wen3 = 0; req_addr3 = 0; req_wdata3 = 0;
        req_size3 = 0; req_unsigned3 = 0; resp_ready3 = 0;
        tick(); tick();
        rst0 = 1'b0; rst3 = 1'b0;

        chk("reset.req_ready",  32'(req_ready0), 32'd1);
        chk("reset.resp_valid", 32'(resp_valid0), 32'd0);
        chk("reset.rdata",      resp_rdata0, 32'h0);
        chk("reset.misalign",   32'(resp_mis0), 32'd0);
        chk("reset.mem_valid",  32'(mem_valid0), 32'd0);
        chk("reset.mem_wen",    32'(mem_wen0), 32'd0);
        chk("reset.raddr",      mem_raddr0, 32'h0);
        chk("reset.waddr",      mem_waddr0, 32'h0);
        chk("reset.wdata",      mem_wdata0, 32'h0);
        chk("reset.wmask",      32'(mem_wmask0), 32'h0);
        chk("reset.ready3",     32'(req_ready3), 32'd1);

        // Half loads from preloaded word 0x8001_1234
        xact0("lh_2",  1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b0, 1'b0, 8'h0C, 32'h0, 32'hFFFF_8001);
        xact0("lhu_2", 1'b0, 32'h8000_0002, 32'h0, 2'd1, 1'b1, 1'b0, 8'h0C, 32'h0, 32'h0000_8001);
        xact0("lh_0",  1'b0, 32'h8000_0000, 32'h0, 2'd1, 1'b0, 1'b0, 8'h03, 32'h0, 32'h0000_1234);
        // Byte store then byte loads
        xact0("sb_3",  1'b1, 32'h8000_0003, 32'h0000_00A5, 2'd0, 1'b0, 1'b0, 8'h08, 32'hA500_0000, 32'h0);
        xact0("lbu_3", 1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b1, 1'b0, 8'h08, 32'h0, 32'h0000_00A5);
        xact0("lb_3",  1'b0, 32'h8000_0003, 32'h0, 2'd0, 1'b0, 1'b0, 8'h08, 32'h0, 32'hFFFF_FFA5);
        xact0("lb_1",  1'b0, 32'h8000_0001, 32'h0, 2'd0, 1'b0, 1'b0, 8'h02, 32'h0, 32'h0000_0012);
        // Word and half stores
        xact0("sw_4",  1'b1, 32'h8000_0004, 32'hDEAD_BEEF, 2'd2, 1'b0, 1'b0, 8'h0F, 32'hDEAD_BEEF, 32'h0);
        xact0("lw_4",  1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 1'b0, 8'h0F, 32'h0, 32'hDEAD_BEEF);
        xact0("sh_6",  1'b1, 32'h8000_0006, 32'h0000_BEEF, 2'd1, 1'b0, 1'b0, 8'h0C, 32'hBEEF_0000, 32'h0);
        xact0("lw_4b", 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 1'b0, 8'h0F, 32'h0, 32'hBEEF_BEEF);
        xact0("lhu_4", 1'b0, 32'h8000_0004, 32'h0, 2'd1, 1'b1, 1'b0, 8'h03, 32'h0, 32'h0000_BEEF);
        // Misaligned and illegal-size requests
        xact0("lw_2",  1'b0, 32'h8000_0002, 32'h0, 2'd2, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0);
        xact0("lh_1",  1'b0, 32'h8000_0001, 32'h0, 2'd1, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0);
        xact0("sw_1",  1'b1, 32'h8000_0001, 32'h1111_1111, 2'd2, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0);
        xact0("sz3_0", 1'b0, 32'h8000_0000, 32'h0, 2'd3, 1'b0, 1'b1, 8'h00, 32'h0, 32'h0);
        xact0("lw_4c", 1'b0, 32'h8000_0004, 32'h0, 2'd2, 1'b0, 1'b0, 8'h0F, 32'h0, 32'hBEEF_BEEF);

        // LATENCY=3 load with slow consumer and req_valid held during the wait
        p = pulses3;
        req_valid3 = 1'b1; req_wen3 = 1'b0; req_addr3 = 32'h8000_0008; req_size3 = 2'd2;
        chk("lat.ready", 32'(req_ready3), 32'd1);
        tick();
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("lat.wait%0d.mem_valid", k), 32'(mem_valid3), 32'd0);
            chk($sformatf("lat.wait%0d.ready", k), 32'(req_ready3), 32'd0);
            chk($sformatf("lat.wait%0d.resp", k), 32'(resp_valid3), 32'd0);
            tick();
        end
        chk("lat.access.mem_valid", 32'(mem_valid3), 32'd1);
        chk("lat.access.raddr", mem_raddr3, 32'h8000_0008);
        chk("lat.access.ready", 32'(req_ready3), 32'd0);
        tick();
        req_valid3 = 1'b0;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("lat.hold%0d.valid", k), 32'(resp_valid3), 32'd1);
            chk($sformatf("lat.hold%0d.rdata", k), resp_rdata3, 32'h1357_9BDF);
            chk($sformatf("lat.hold%0d.ready", k), 32'(req_ready3), 32'd0);
            chk($sformatf("lat.hold%0d.mem", k), 32'(mem_valid3), 32'd0);
            tick();
        end
        resp_ready3 = 1'b1;
        tick();
        resp_ready3 = 1'b0;
        chk("lat.done.valid", 32'(resp_valid3), 32'd0);
        chk("lat.done.ready", 32'(req_ready3), 32'd1);
        chk("lat.pulses", 32'(pulses3 - p), 32'd1);
        $display("xact lat3_lw addr=80000008 pulses=%0d", pulses3 - p);

        // Reset during WAIT
        p = pulses3;
        req_valid3 = 1'b1; req_addr3 = 32'h8000_000C; req_size3 = 2'd2;
        tick();
        req_valid3 = 1'b0;
        tick();
        chk("rstwait.in_wait", 32'(req_ready3), 32'd0);
        rst3 = 1'b1;
        tick();
        rst3 = 1'b0;
        chk("rstwait.ready", 32'(req_ready3), 32'd1);
        chk("rstwait.resp", 32'(resp_valid3), 32'd0);
        chk("rstwait.mem", 32'(mem_valid3), 32'd0);
        repeat (6) tick();
        chk("rstwait.pulses", 32'(pulses3 - p), 32'd0);
        $display("xact rst_wait pulses=%0d", pulses3 - p);

        // Reset during RESP
        req_valid0 = 1'b1; req_wen0 = 1'b0; req_addr0 = 32'h8000_0004; req_size0 = 2'd2;
        tick();
        req_valid0 = 1'b0;
        tick();
        chk("rstresp.valid", 32'(resp_valid0), 32'd1);
        chk("rstresp.rdata", resp_rdata0, 32'hBEEF_BEEF);
        p = pulses0;
        rst0 = 1'b1;
        tick();
        rst0 = 1'b0;
        chk("rstresp.cleared", 32'(resp_valid0), 32'd0);
        chk("rstresp.rdata0", resp_rdata0, 32'h0);
        chk("rstresp.ready", 32'(req_ready0), 32'd1);
        repeat (4) tick();
        chk("rstresp.pulses", 32'(pulses0 - p), 32'd0);
        $display("xact rst_resp pulses=%0d", pulses0 - p);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
